// File: rtl/bcd_pkg.sv
// Shared constants and FSM state type for the binary-to-BCD converters.
`timescale 1ns/1ps
package bcd_pkg;
    localparam int              DIGIT_W    = 4;
    localparam logic [3:0]      ADJ_THRESH = 4'd5;
    localparam logic [3:0]      ADJ_ADD    = 4'd3;
    localparam logic [3:0]      BCD_NINE   = 4'h9;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;
endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more,
// so the following left shift carries correctly into the next decade.
`timescale 1ns/1ps
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] din,
    output logic [DIGIT_W-1:0] dout
);
    assign dout = (din >= ADJ_THRESH) ? din + ADJ_ADD : din;
endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one bit per clock,
// with start/busy/done handshake and exact overflow flag. Define BCD_BLANK_EN
// to add the registered leading-zero blanking output.
`timescale 1ns/1ps
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int DATA_W = 20,
    parameter int DIGITS = 6
)
(
    input  logic                      sys_clk,
    input  logic                      sys_rst_n,
    input  logic                      start,
    input  logic [DATA_W-1:0]         data,
    output logic                      busy,
    output logic                      done,
    output logic [DIGIT_W*DIGITS-1:0] bcd,
    output logic                      ovf
`ifdef BCD_BLANK_EN
    ,
    output logic [DIGITS-1:0]         blank
`endif
);
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int ACC_W = DIGIT_W * DIGITS;

    state_t             state_reg, state_next;
    logic [DATA_W-1:0]  shift_reg, shift_next;
    logic [ACC_W-1:0]   acc_reg, acc_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               sticky_reg, sticky_next;
    logic [ACC_W-1:0]   bcd_reg, bcd_next;
    logic               ovf_reg, ovf_next;

    logic [ACC_W-1:0]   acc_adj;
    logic [ACC_W-1:0]   acc_shift;
    logic [ACC_W-1:0]   nine_word;
    logic               sticky_final;
    logic               last_shift;

`ifdef BCD_BLANK_EN
    logic [DIGITS-1:0]  blank_reg, blank_next, blank_calc;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            bcd_digit_adj u_adj (
                .din  (acc_reg[gi*DIGIT_W +: DIGIT_W]),
                .dout (acc_adj[gi*DIGIT_W +: DIGIT_W])
            );
            assign nine_word[gi*DIGIT_W +: DIGIT_W] = BCD_NINE;
`ifdef BCD_BLANK_EN
            // The units digit is always shown, even for zero.
            if (gi == 0) begin : g_units
                assign blank_calc[gi] = 1'b0;
            end else begin : g_upper
                assign blank_calc[gi] = ~|acc_shift[ACC_W-1:gi*DIGIT_W];
            end
`endif
        end
    endgenerate

    // Top bit of the adjusted accumulator is the carry lost off the last digit.
    assign acc_shift    = {acc_adj[ACC_W-2:0], shift_reg[DATA_W-1]};
    assign sticky_final = sticky_reg | acc_adj[ACC_W-1];
    assign last_shift   = (cnt_reg == CNT_W'(DATA_W - 1));

    always_comb begin
        state_next  = state_reg;
        shift_next  = shift_reg;
        acc_next    = acc_reg;
        cnt_next    = cnt_reg;
        sticky_next = sticky_reg;
        bcd_next    = bcd_reg;
        ovf_next    = ovf_reg;
`ifdef BCD_BLANK_EN
        blank_next  = blank_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (start) begin
                    shift_next  = data;
                    acc_next    = '0;
                    cnt_next    = '0;
                    sticky_next = 1'b0;
                    state_next  = SHIFT;
                end
            end
            SHIFT: begin
                shift_next  = shift_reg << 1;
                acc_next    = acc_shift;
                sticky_next = sticky_final;
                cnt_next    = cnt_reg + CNT_W'(1);
                // Results are loaded on the final shift so they are valid while done is high.
                if (last_shift) begin
                    state_next = DONE;
                    bcd_next   = sticky_final ? nine_word : acc_shift;
                    ovf_next   = sticky_final;
`ifdef BCD_BLANK_EN
                    blank_next = sticky_final ? '0 : blank_calc;
`endif
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_reg  <= IDLE;
            shift_reg  <= '0;
            acc_reg    <= '0;
            cnt_reg    <= '0;
            sticky_reg <= 1'b0;
            bcd_reg    <= '0;
            ovf_reg    <= 1'b0;
`ifdef BCD_BLANK_EN
            blank_reg  <= '0;
`endif
        end else begin
            state_reg  <= state_next;
            shift_reg  <= shift_next;
            acc_reg    <= acc_next;
            cnt_reg    <= cnt_next;
            sticky_reg <= sticky_next;
            bcd_reg    <= bcd_next;
            ovf_reg    <= ovf_next;
`ifdef BCD_BLANK_EN
            blank_reg  <= blank_next;
`endif
        end
    end

    assign busy = (state_reg != IDLE);
    assign done = (state_reg == DONE);
    assign bcd  = bcd_reg;
    assign ovf  = ovf_reg;
`ifdef BCD_BLANK_EN
    assign blank = blank_reg;
`endif
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: a 20-bit/6-digit and an 8-bit/2-digit instance,
// checked against a decimal arithmetic reference model.
`timescale 1ns/1ps
module tb_bin2bcd_seq;
    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        start, start8;
    logic [19:0] data;
    logic [7:0]  data8;
    logic        busy, done, ovf;
    logic [23:0] bcd;
    logic        busy8, done8, ovf8;
    logic [7:0]  bcd8;
`ifdef BCD_BLANK_EN
    logic [5:0]  blank;
    logic [1:0]  blank8;
`endif

    int checks = 0;
    int passed = 0;
    logic [63:0] hold_bcd;
    logic [63:0] hold_blank;
    bit          hold_ovf;

    always #5 sys_clk = ~sys_clk;

    bin2bcd_seq #(.DATA_W(20), .DIGITS(6)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .start     (start),
        .data      (data),
        .busy      (busy),
        .done      (done),
        .bcd       (bcd),
        .ovf       (ovf)
`ifdef BCD_BLANK_EN
        ,
        .blank     (blank)
`endif
    );

    bin2bcd_seq #(.DATA_W(8), .DIGITS(2)) dut8 (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .start     (start8),
        .data      (data8),
        .busy      (busy8),
        .done      (done8),
        .bcd       (bcd8),
        .ovf       (ovf8)
`ifdef BCD_BLANK_EN
        ,
        .blank     (blank8)
`endif
    );

    // Reference: plain decimal arithmetic, saturating to all nines on overflow.
    function automatic logic [63:0] ref_bcd(input longint v, input int nd, output bit o);
        logic [63:0] r = '0;
        longint lim = 1;
        longint x = v;
        for (int i = 0; i < nd; i++) lim = lim * 10;
        o = (v >= lim);
        for (int i = 0; i < nd; i++) begin
            if (o) begin
                r[4*i +: 4] = 4'd9;
            end else begin
                r[4*i +: 4] = 4'(x % 10);
                x = x / 10;
            end
        end
        return r;
    endfunction

    function automatic logic [63:0] ref_blank(input longint v, input int nd);
        logic [63:0] r = '0;
        longint lim = 1;
        longint p = 1;
        for (int i = 0; i < nd; i++) lim = lim * 10;
        if (v >= lim) return r;
        for (int i = 1; i < nd; i++) begin
            p = p * 10;
            r[i] = ((v / p) == 0);
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic conv20(input logic [19:0] v, input bit interfere);
        logic [63:0] eb;
        bit eo;
        bit seen = 1'b0;
        eb = ref_bcd(longint'(v), 6, eo);
        @(posedge sys_clk); #1;
        chk("idle_busy", 64'(busy), 64'(0));
        chk("idle_done", 64'(done), 64'(0));
        data  = v;
        start = 1'b1;
        @(posedge sys_clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (interfere && (k == 5 || k == 21)) begin
                start = 1'b1;
                data  = 20'd55;
            end else begin
                start = 1'b0;
            end
            chk("busy_high", 64'(busy), 64'(1));
            if (k == 10) begin
                chk("hold_bcd", 64'(bcd), hold_bcd);
                chk("hold_ovf", 64'(ovf), 64'(hold_ovf));
            end
            if (done) begin
                seen = 1'b1;
                chk("latency", 64'(k), 64'(21));
                chk("bcd", 64'(bcd), eb);
                chk("ovf", 64'(ovf), 64'(eo));
`ifdef BCD_BLANK_EN
                chk("blank", 64'(blank), ref_blank(longint'(v), 6));
                hold_blank = ref_blank(longint'(v), 6);
`endif
                hold_bcd = eb;
                hold_ovf = eo;
                $display("conv20 data=%0d bcd=%h ovf=%0b latency=%0d", v, bcd, ovf, k);
                break;
            end
            @(posedge sys_clk); #1;
        end
        chk("done_seen", 64'(seen), 64'(1));
    endtask

    task automatic conv8(input logic [7:0] v);
        logic [63:0] eb;
        bit eo;
        bit seen = 1'b0;
        eb = ref_bcd(longint'(v), 2, eo);
        @(posedge sys_clk); #1;
        chk("idle_busy8", 64'(busy8), 64'(0));
        data8  = v;
        start8 = 1'b1;
        @(posedge sys_clk); #1;
        start8 = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (done8) begin
                seen = 1'b1;
                chk("latency8", 64'(k), 64'(9));
                chk("bcd8", 64'(bcd8), eb);
                chk("ovf8", 64'(ovf8), 64'(eo));
`ifdef BCD_BLANK_EN
                chk("blank8", 64'(blank8), ref_blank(longint'(v), 2));
`endif
                $display("conv8 data=%0d bcd=%h ovf=%0b latency=%0d", v, bcd8, ovf8, k);
                break;
            end
            @(posedge sys_clk); #1;
        end
        chk("done8_seen", 64'(seen), 64'(1));
    endtask

    initial begin
        int spurious;
        sys_rst_n = 1'b0;
        start     = 1'b0;
        start8    = 1'b0;
        data      = '0;
        data8     = '0;
        hold_bcd  = '0;
        hold_ovf  = 1'b0;
        hold_blank = '0;
        repeat (3) @(posedge sys_clk);
        #1;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_bcd",  64'(bcd),  64'(0));
        chk("rst_ovf",  64'(ovf),  64'(0));
        chk("rst_bcd8", 64'(bcd8), 64'(0));
`ifdef BCD_BLANK_EN
        chk("rst_blank", 64'(blank), 64'(0));
`endif
        sys_rst_n = 1'b1;

        conv20(20'd0, 1'b0);
        conv20(20'd123456, 1'b0);
        conv20(20'd999999, 1'b0);
        conv20(20'd1000000, 1'b0);
        conv20(20'd1048575, 1'b0);
        conv20(20'd7, 1'b0);
        conv20(20'd42, 1'b0);
        conv20(20'd777, 1'b1);
        conv20(20'd31337, 1'b0);
        for (int i = 0; i < 6; i++) conv20(20'($urandom_range(0, 999999)), 1'b0);
        for (int i = 0; i < 6; i++) conv20(20'($urandom_range(0, 20'hFFFFF)), 1'b0);
        start = 1'b0;

        conv8(8'd255);
        conv8(8'd99);
        conv8(8'd100);
        conv8(8'd0);
        conv8(8'd10);
        for (int i = 0; i < 4; i++) conv8(8'($urandom_range(0, 255)));

        // Reset in the middle of a conversion.
        @(posedge sys_clk); #1;
        data  = 20'd654321;
        start = 1'b1;
        @(posedge sys_clk); #1;
        start = 1'b0;
        repeat (9) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_done", 64'(done), 64'(0));
        chk("mid_rst_bcd",  64'(bcd),  64'(0));
        chk("mid_rst_ovf",  64'(ovf),  64'(0));
`ifdef BCD_BLANK_EN
        chk("mid_rst_blank", 64'(blank), 64'(0));
`endif
        @(posedge sys_clk); #1;
        sys_rst_n = 1'b1;
        spurious = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge sys_clk); #1;
            if (done || busy) spurious++;
        end
        chk("no_done_after_rst", 64'(spurious), 64'(0));
        $display("reset mid-conversion: spurious_cycles=%0d", spurious);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
Parametrised sequential binary-to-BCD converter using the shift-and-add-3 (double dabble) algorithm, for the frequency-meter display path and other numeric readouts.
- Generalises the fixed 20-bit / 6-digit free-running converter to arbitrary input width and digit count.
- Adds an explicit start/busy/done handshake and an overflow flag.
- Performs one adjust-and-shift per clock.

Parameters:
DATA_W, 20, binary input width in bits (>=1)
DIGITS, 6, number of BCD output digits (>=1)
CNT_W, $clog2(DATA_W+1), shift-counter width (derived localparam, not overridable)

Ports:
sys_clk  input  1  system clock; all logic on rising edge
sys_rst_n  input  1  asynchronous active-low reset
start  input  1  conversion request; sampled only in IDLE
data  input  DATA_W  unsigned binary value; captured on the accepted start cycle
busy  output  1  high whenever state != IDLE
done  output  1  single-cycle pulse; bcd and ovf valid and updated that cycle
bcd  output  4*DIGITS  packed BCD result; digit 0 (units) in [3:0]; held until the next done
ovf  output  1  result did not fit in DIGITS digits; held with bcd

Behaviour:
- Reset (asynchronous, any time, including mid-conversion):
  - state=IDLE, busy=0, done=0, bcd=0, ovf=0; internal shift register, accumulator and counter cleared.
  - An in-flight conversion is discarded.
- IDLE:
  - start=1 latches data into the shift register, clears the accumulator, cnt=0 and the sticky overflow, then moves to SHIFT.
  - start=0: remain in IDLE.
- SHIFT, per cycle:
  - Every 4-bit accumulator digit >=5 gets +3 (all digits in parallel).
  - {accumulator, shift register} then shifts left by 1 in the same cycle, MSB of data entering digit 0 LSB.
  - The bit shifted out of the top digit ORs into sticky overflow.
  - cnt increments; after DATA_W shift cycles, go to DONE.
- DONE (one cycle):
  - done=1.
  - bcd <= sticky overflow ? all digits 4'h9 : accumulator.
  - ovf <= sticky overflow.
  - Next state IDLE.
- Latency: start accepted at edge N gives done=1 during cycle N+DATA_W+1; busy high for cycles N+1 through N+DATA_W+1.
- Earliest next acceptance: start high in the cycle after done; back-to-back throughput is one result per DATA_W+2 cycles.
- start while busy (including the done cycle) is ignored and not queued; data changes while busy have no effect.
- Arithmetic:
  - Accumulator is exactly 4*DIGITS bits and is never widened.
  - Overflow is exact: asserted iff data >= 10^DIGITS.
- Degenerate sizing: if 4*DIGITS >= DATA_W+ceil(DATA_W/3), overflow is unreachable and the logic may be left in place.
- bcd/ovf never glitch or change outside a done cycle or reset.

Optional Feature:
Macro BCD_BLANK_EN.
- Defined:
  - Adds output port blank [DIGITS-1:0], registered and updated with bcd on done; reset 0.
  - blank[i]=1 iff digit i and all higher digits are 0, for i>=1.
  - blank[0] is always 0.
  - With ovf=1, blank is all 0.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Shared package bcd_pkg:
  - DIGIT_W=4, ADJ_THRESH=4'd5, ADJ_ADD=4'd3.
  - State enum typedef {IDLE, SHIFT, DONE}.
  - Constant BCD_NINE=4'h9.
- One natural combinational sub-module, bcd_digit_adj: 4-bit in, 4-bit out, applies add-3 when >=5.
  - Instantiated DIGITS times via generate.
  - Reused by any future parallel converter.

Test Plan:
- Reset, then start with data=0 -> done at cycle 21 after start, bcd=24'h000000, ovf=0, busy high for cycles 1..21.
- data=20'd123456 -> bcd=24'h123456, ovf=0; data=20'd999999 -> bcd=24'h999999, ovf=0.
- data=20'd1000000 and data=20'd1048575 -> ovf=1, bcd=24'h999999; then data=20'd7 -> ovf=0, bcd=24'h000007.
- start pulsed at cycles 5 and 21 after an accepted start (data changed to 20'd55) -> ignored; result still that of the original data; start at cycle 22 is accepted.
- Assert sys_rst_n low at cycle 10 of a conversion -> all outputs 0 immediately; after release, no done appears without a new start.
- BCD_BLANK_EN, data=20'd42 -> blank=6'b111100; data=0 -> blank=6'b111110; DATA_W=8, DIGITS=2, data=8'd255 -> ovf=1, bcd=8'h99, blank=2'b00.
